filter_sched: RTL

Controller that computes the second-order recursive filter y[n] = A²·y[n-2] + A·B·x[n-1] + B·x[n] using one shared, externally instantiated pipelined multiplier instead of three dedicated ones. It accepts one input sample per valid/ready handshake and issues the three products back-to-back into the multiplier. It accumulates the returned products, holds the result under output backpressure, and maintains the x[n-1], y[n-1] and y[n-2] history. It sits between the sample source and the filter output stage and owns the multiplier's operand ports.

---
 rtl/filter_sched.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/filter_sched.sv
// -----------------------------------------------------------------------------
// filter_sched
//   Scheduler for the second-order recursive filter
//     y[n] = A*A*y[n-2] + A*B*x[n-1] + B*x[n]
//   built around one shared, externally instantiated pipelined multiplier.
//   Each accepted sample issues three products back-to-back:
//     (B, x[n]), (A*B, x[n-1]), (A*A, y[n-2]).
//   The returned products are summed. The result is then held until the
//   consumer takes it. The x[n-1] / y[n-1] / y[n-2] history advances once per
//   completed sample. All arithmetic wraps modulo 2^WIDTH.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   in_valid   in   x_in carries a sample
//   in_ready   out  block can accept a sample (IDLE only)
//   x_in       in   input sample x[n]
//   out_valid  out  y_out carries a result
//   out_ready  in   consumer accepts y_out
//   y_out      out  filter output y[n]
//   mul_en     out  mul_a/mul_b carry a product request this cycle
//   mul_a      out  coefficient operand (0 when idle)
//   mul_b      out  data operand (0 when idle)
//   mul_p      in   product, MUL_LAT edges after the operands were sampled
//   busy       out  FSM is not in IDLE
// -----------------------------------------------------------------------------
module filter_sched #(
  parameter int unsigned WIDTH   = 32,
  parameter int          A       = 2,
  parameter int          B       = 3,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y_out,
  output logic             mul_en,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic [WIDTH-1:0] mul_p,
  output logic             busy
);

  localparam logic [WIDTH-1:0] B_C  = WIDTH'(B);
  localparam logic [WIDTH-1:0] AB_C = WIDTH'(A * B);
  localparam logic [WIDTH-1:0] AA_C = WIDTH'(A * A);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [1:0]         cnt_r;       // issue slot currently presented
  logic [1:0]         ret_cnt_r;   // tagged products accumulated so far
  logic [WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]   x_cap_r;
  logic [WIDTH-1:0]   x_prev_r;
  logic [WIDTH-1:0]   y_h1_r;
  logic [WIDTH-1:0]   y_h2_r;
  logic [MUL_LAT-1:0] tag_r;

  logic               in_ready_r;
  logic               out_valid_r;
  logic [WIDTH-1:0]   y_out_r;
  logic               mul_en_r;
  logic [WIDTH-1:0]   mul_a_r;
  logic [WIDTH-1:0]   mul_b_r;
  logic               busy_r;

  logic               accept_s;
  logic               release_s;
  logic               tag_out_s;
  logic               done_s;
  logic [WIDTH-1:0]   y_new_s;
  logic               mul_en_s;
  logic [WIDTH-1:0]   mul_a_s;
  logic [WIDTH-1:0]   mul_b_s;
  logic               in_ready_s;
  logic               busy_s;

  // in_ready_r is only ever high in IDLE; gating with it keeps the first
  // cycle after reset (state IDLE, in_ready still low) from accepting.
  assign accept_s  = (state_r == ST_IDLE) && in_valid && in_ready_r;
  assign release_s = (state_r == ST_OUT) && out_valid_r && out_ready;
  assign tag_out_s = tag_r[MUL_LAT-1];
  assign y_new_s   = acc_r + mul_p;
  assign done_s    = (state_r == ST_DRAIN) && tag_out_s && (ret_cnt_r == 2'd2);

  // State register and issue-slot counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 2'd0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        cnt_r <= 2'd0;
      end else if (state_r == ST_ISSUE) begin
        cnt_r <= cnt_r + 2'd1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_ISSUE;
        else          state_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (cnt_r == 2'd2) state_s = ST_DRAIN;
        else               state_s = ST_ISSUE;
      end
      ST_DRAIN: begin
        if (done_s) state_s = ST_OUT;
        else        state_s = ST_DRAIN;
      end
      ST_OUT: begin
        if (release_s) state_s = ST_IDLE;
        else           state_s = ST_OUT;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Next-cycle output decode; the values are registered below so every
  // output comes straight from a flop. Slot 0 is entered only on accept,
  // so its data operand is taken directly from x_in.
  always_comb begin
    mul_en_s = 1'b0;
    mul_a_s  = '0;
    mul_b_s  = '0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          mul_en_s = 1'b1;
          mul_a_s  = B_C;
          mul_b_s  = x_in;
        end else begin
          mul_en_s = 1'b0;
          mul_a_s  = '0;
          mul_b_s  = '0;
        end
      end
      ST_ISSUE: begin
        if (cnt_r == 2'd0) begin
          mul_en_s = 1'b1;
          mul_a_s  = AB_C;
          mul_b_s  = x_prev_r;
        end else if (cnt_r == 2'd1) begin
          mul_en_s = 1'b1;
          mul_a_s  = AA_C;
          mul_b_s  = y_h2_r;
        end else begin
          mul_en_s = 1'b0;
          mul_a_s  = '0;
          mul_b_s  = '0;
        end
      end
      default: begin
        mul_en_s = 1'b0;
        mul_a_s  = '0;
        mul_b_s  = '0;
      end
    endcase
    in_ready_s = (state_s == ST_IDLE);
    busy_s     = (state_s != ST_IDLE);
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      mul_en_r   <= 1'b0;
      mul_a_r    <= '0;
      mul_b_r    <= '0;
    end else begin
      in_ready_r <= in_ready_s;
      busy_r     <= busy_s;
      mul_en_r   <= mul_en_s;
      mul_a_r    <= mul_a_s;
      mul_b_r    <= mul_b_s;
    end
  end

  // Issue tag pipeline: a tag leaves the last stage on the same edge its
  // product is valid on mul_p. Clearing it on reset discards in-flight work.
  generate
    if (MUL_LAT == 1) begin : g_tag_single
      // Single-stage tag.
      always_ff @(posedge clk) begin
        if (reset) tag_r <= '0;
        else       tag_r <= mul_en_r;
      end
    end else begin : g_tag_multi
      // Multi-stage tag shift register.
      always_ff @(posedge clk) begin
        if (reset) tag_r <= '0;
        else       tag_r <= {tag_r[MUL_LAT-2:0], mul_en_r};
      end
    end
  endgenerate

  // Accumulator, sample capture, result register and filter history.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r       <= '0;
      ret_cnt_r   <= 2'd0;
      x_cap_r     <= '0;
      x_prev_r    <= '0;
      y_h1_r      <= '0;
      y_h2_r      <= '0;
      y_out_r     <= '0;
      out_valid_r <= 1'b0;
    end else begin
      if (accept_s) begin
        x_cap_r   <= x_in;
        acc_r     <= '0;
        ret_cnt_r <= 2'd0;
      end else if (tag_out_s && ((state_r == ST_ISSUE) || (state_r == ST_DRAIN))) begin
        acc_r     <= y_new_s;
        ret_cnt_r <= ret_cnt_r + 2'd1;
      end
      if (done_s) begin
        y_out_r     <= y_new_s;
        out_valid_r <= 1'b1;
        y_h2_r      <= y_h1_r;
        y_h1_r      <= y_new_s;
        x_prev_r    <= x_cap_r;
      end else if (release_s) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign y_out     = y_out_r;
  assign mul_en    = mul_en_r;
  assign mul_a     = mul_a_r;
  assign mul_b     = mul_b_r;
  assign busy      = busy_r;

endmodule
